// File: rtl/vga_sync_rx.sv
// VGA sync receiver: measures line/frame timing from HS/VS, tracks live position
// and reports lock once the measured timing repeats for LOCK_FRAMES frames.
module vga_sync_rx #(
    parameter int SYNC_ACTIVE_LOW = 1,
    parameter int LOCK_FRAMES     = 2
) (
    input  logic       m_clock,
    input  logic       p_reset,
    input  logic       pix_en,
    input  logic       hs_in,
    input  logic       vs_in,
    output logic [9:0] h_total,
    output logic [9:0] h_sync_w,
    output logic [9:0] v_total,
    output logic [9:0] v_sync_w,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       frame_pulse,
    output logic       locked,
    output logic       err
);

    localparam int unsigned CW = 10;
    localparam int unsigned MW = 4;
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        TRACK  = 2'd1,
        LOCK   = 2'd2
    } lock_state_e;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == CNT_MAX) ? CNT_MAX : v + CW'(1);
    endfunction

    lock_state_e   state;
    logic          hs_d;
    logic          vs_d;
    logic [CW-1:0] h_cnt;
    logic [CW-1:0] v_cnt;
    logic [CW-1:0] hs_w_cnt;
    logic [CW-1:0] vs_w_cnt;
    logic [CW-1:0] ref_h;
    logic [CW-1:0] ref_v;
    logic [MW-1:0] match_cnt;

    logic          hs_act_c;
    logic          vs_act_c;
    logic          hs_lead_c;
    logic          hs_trail_c;
    logic          vs_lead_c;
    logic          vs_trail_c;
    logic [CW-1:0] h_cnt_nxt_c;
    logic [CW-1:0] v_cnt_nxt_c;
    logic [CW-1:0] h_new_c;
    logic [CW-1:0] v_new_c;
    logic          sat_hit_c;
    logic          meas_eq_c;

    assign x = h_cnt;
    assign y = v_cnt;

    // Polarity normalisation, edge detection and next counter values
    always_comb begin
        hs_act_c    = (SYNC_ACTIVE_LOW != 0) ? ~hs_in : hs_in;
        vs_act_c    = (SYNC_ACTIVE_LOW != 0) ? ~vs_in : vs_in;
        hs_lead_c   = pix_en & hs_act_c & ~hs_d;
        hs_trail_c  = pix_en & ~hs_act_c & hs_d;
        vs_lead_c   = pix_en & vs_act_c & ~vs_d;
        vs_trail_c  = pix_en & ~vs_act_c & vs_d;

        h_cnt_nxt_c = hs_lead_c ? '0 : sat_inc(h_cnt);
        v_cnt_nxt_c = v_cnt;
        if (vs_lead_c) begin
            v_cnt_nxt_c = '0;
        end else if (hs_lead_c) begin
            v_cnt_nxt_c = sat_inc(v_cnt);
        end

        // A VS edge coincident with an HS edge closes the line in the same sample
        h_new_c   = hs_lead_c ? sat_inc(h_cnt) : h_total;
        v_new_c   = sat_inc(v_cnt);
        sat_hit_c = (h_cnt_nxt_c == CNT_MAX) || (v_cnt_nxt_c == CNT_MAX);
        meas_eq_c = (h_new_c == ref_h) && (v_new_c == ref_v);
    end

    always_ff @(posedge m_clock) begin
        if (!p_reset) begin
            state       <= SEARCH;
            hs_d        <= 1'b0;
            vs_d        <= 1'b0;
            h_cnt       <= '0;
            v_cnt       <= '0;
            hs_w_cnt    <= '0;
            vs_w_cnt    <= '0;
            ref_h       <= '0;
            ref_v       <= '0;
            match_cnt   <= '0;
            h_total     <= '0;
            h_sync_w    <= '0;
            v_total     <= '0;
            v_sync_w    <= '0;
            frame_pulse <= 1'b0;
            locked      <= 1'b0;
            err         <= 1'b0;
        end else begin
            frame_pulse <= vs_lead_c;
            if (pix_en) begin
                hs_d  <= hs_act_c;
                vs_d  <= vs_act_c;
                h_cnt <= h_cnt_nxt_c;
                v_cnt <= v_cnt_nxt_c;

                if (hs_lead_c) begin
                    h_total <= h_new_c;
                end
                if (vs_lead_c) begin
                    v_total <= v_new_c;
                end

                // Sync width measurement
                if (hs_lead_c) begin
                    hs_w_cnt <= CW'(1);
                end else if (hs_act_c) begin
                    hs_w_cnt <= sat_inc(hs_w_cnt);
                end
                if (hs_trail_c) begin
                    h_sync_w <= hs_w_cnt;
                end
                if (vs_lead_c) begin
                    vs_w_cnt <= hs_lead_c ? CW'(1) : '0;
                end else if (vs_act_c && hs_lead_c) begin
                    vs_w_cnt <= sat_inc(vs_w_cnt);
                end
                if (vs_trail_c) begin
                    v_sync_w <= vs_w_cnt;
                end

                // Lock tracking; counter saturation overrides everything
                if (sat_hit_c) begin
                    err    <= 1'b1;
                    state  <= SEARCH;
                    locked <= 1'b0;
                end else if (vs_lead_c) begin
                    case (state)
                        SEARCH: begin
                            ref_h     <= h_new_c;
                            ref_v     <= v_new_c;
                            match_cnt <= '0;
                            state     <= TRACK;
                            locked    <= 1'b0;
                        end
                        TRACK: begin
                            if (meas_eq_c) begin
                                match_cnt <= match_cnt + MW'(1);
                                if (match_cnt + MW'(1) == MW'(LOCK_FRAMES)) begin
                                    state  <= LOCK;
                                    locked <= 1'b1;
                                end
                            end else begin
                                ref_h     <= h_new_c;
                                ref_v     <= v_new_c;
                                match_cnt <= '0;
                            end
                        end
                        LOCK: begin
                            if (!meas_eq_c) begin
                                ref_h     <= h_new_c;
                                ref_v     <= v_new_c;
                                match_cnt <= '0;
                                state     <= TRACK;
                                locked    <= 1'b0;
                            end
                        end
                        default: begin
                            state  <= SEARCH;
                            locked <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_vga_sync_rx.sv
// Bench for vga_sync_rx: scaled-down video timing driven into an active-low and
// an active-high instance; per-frame expectations are checked on frame_pulse.
module tb_vga_sync_rx;

    localparam int H_TOT = 40;
    localparam int H_SW  = 6;
    localparam int V_TOT = 12;
    localparam int V_SW  = 2;

    typedef struct {
        logic [9:0] ht;
        logic [9:0] hw;
        logic [9:0] vt;
        logic [9:0] vw;
        logic       lk;
        logic       er;
    } exp_t;

    logic       m_clock = 1'b0;
    logic       p_reset = 1'b0;
    logic       pix_en  = 1'b0;
    logic       hs_lo   = 1'b1;
    logic       vs_lo   = 1'b1;

    logic [9:0] h_total, h_sync_w, v_total, v_sync_w, x, y;
    logic       frame_pulse, locked, err;
    logic [9:0] h_total_hi, h_sync_w_hi, v_total_hi, v_sync_w_hi, x_hi, y_hi;
    logic       frame_pulse_hi, locked_hi, err_hi;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb_q[$];

    always #5 m_clock = ~m_clock;

    vga_sync_rx #(.SYNC_ACTIVE_LOW(1), .LOCK_FRAMES(2)) dut (
        .m_clock(m_clock), .p_reset(p_reset), .pix_en(pix_en),
        .hs_in(hs_lo), .vs_in(vs_lo),
        .h_total(h_total), .h_sync_w(h_sync_w), .v_total(v_total), .v_sync_w(v_sync_w),
        .x(x), .y(y), .frame_pulse(frame_pulse), .locked(locked), .err(err)
    );

    vga_sync_rx #(.SYNC_ACTIVE_LOW(0), .LOCK_FRAMES(2)) dut_hi (
        .m_clock(m_clock), .p_reset(p_reset), .pix_en(pix_en),
        .hs_in(~hs_lo), .vs_in(~vs_lo),
        .h_total(h_total_hi), .h_sync_w(h_sync_w_hi), .v_total(v_total_hi), .v_sync_w(v_sync_w_hi),
        .x(x_hi), .y(y_hi), .frame_pulse(frame_pulse_hi), .locked(locked_hi), .err(err_hi)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // One pix_en sample followed by an idle clock with random sync noise
    task automatic step(input logic hs_a, input logic vs_a);
        @(posedge m_clock); #1;
        pix_en = 1'b1;
        hs_lo  = ~hs_a;
        vs_lo  = ~vs_a;
        @(posedge m_clock); #1;
        pix_en = 1'b0;
        hs_lo  = 1'($urandom);
        vs_lo  = 1'($urandom);
    endtask

    task automatic lines(input int first, input int last, input int last_len);
        for (int l = first; l <= last; l++) begin
            int len;
            len = (l == V_TOT - 1) ? last_len : H_TOT;
            for (int s = 0; s < len; s++) begin
                step(s < H_SW, l < V_SW);
            end
        end
    endtask

    task automatic frame(input exp_t e, input int last_len);
        sb_q.push_back(e);
        lines(0, V_TOT - 1, last_len);
    endtask

    function automatic exp_t mk(input int ht, input int hw, input int vt, input int vw,
                                input bit lk, input bit er);
        exp_t e;
        e.ht = 10'(ht);
        e.hw = 10'(hw);
        e.vt = 10'(vt);
        e.vw = 10'(vw);
        e.lk = lk;
        e.er = er;
        return e;
    endfunction

    task automatic check_zero(input string nm);
        check(nm, {h_total, h_sync_w, v_total, v_sync_w},      32'd0);
        check(nm, {x, y, frame_pulse, locked, err},             32'd0);
        check(nm, {h_total_hi, v_total_hi, x_hi, locked_hi, err_hi}, 32'd0);
    endtask

    // Monitor: every frame_pulse pops one expected frame-edge record
    always @(negedge m_clock) begin
        if (p_reset && (frame_pulse || frame_pulse_hi)) begin
            check("pulse_hi_vs_lo", 32'(frame_pulse_hi), 32'(frame_pulse));
            if (sb_q.size() == 0) begin
                check("unexpected_pulse", 32'(sb_q.size()), 32'd1);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("h_total",    32'(h_total),    32'(e.ht));
                check("h_sync_w",   32'(h_sync_w),   32'(e.hw));
                check("v_total",    32'(v_total),    32'(e.vt));
                check("v_sync_w",   32'(v_sync_w),   32'(e.vw));
                check("locked",     32'(locked),     32'(e.lk));
                check("err",        32'(err),        32'(e.er));
                check("xy_at_edge", {6'd0, x, 6'd0, y}, 32'd0);
                check("hi_meas", {h_total_hi, h_sync_w_hi, 2'd0, v_total_hi[9:0]},
                                 {e.ht, e.hw, 2'd0, e.vt});
                check("hi_vsync_w", 32'(v_sync_w_hi), 32'(e.vw));
                check("hi_locked",  32'(locked_hi),   32'(e.lk));
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(posedge m_clock);
        #1;
        check_zero("reset_state");
        p_reset = 1'b1;

        // Acquisition: first edge sees post-reset counters, lock at 3rd edge after it
        frame(mk(1, 0, 1, 0, 0, 0), H_TOT);
        frame(mk(H_TOT, H_SW, V_TOT, V_SW, 0, 0), H_TOT);
        frame(mk(H_TOT, H_SW, V_TOT, V_SW, 0, 0), H_TOT);
        frame(mk(H_TOT, H_SW, V_TOT, V_SW, 1, 0), H_TOT);
        frame(mk(H_TOT, H_SW, V_TOT, V_SW, 1, 0), H_TOT);

        // Last line one sample long: loses lock, re-acquires
        frame(mk(H_TOT, H_SW, V_TOT, V_SW, 1, 0), H_TOT + 1);
        frame(mk(H_TOT + 1, H_SW, V_TOT, V_SW, 0, 0), H_TOT);
        frame(mk(H_TOT, H_SW, V_TOT, V_SW, 0, 0), H_TOT);
        frame(mk(H_TOT, H_SW, V_TOT, V_SW, 0, 0), H_TOT);
        frame(mk(H_TOT, H_SW, V_TOT, V_SW, 1, 0), H_TOT);
        frame(mk(H_TOT, H_SW, V_TOT, V_SW, 1, 0), H_TOT);

        // HS stalls long enough to saturate the line counter
        for (int i = 0; i < 1100; i++) begin
            step(1'b0, 1'b0);
        end
        check("x_saturated", 32'(x), 32'd1023);
        check("y_held",      32'(y), 32'(V_TOT - 1));
        check("err_set",     32'(err), 32'd1);
        check("unlock_sat",  32'(locked), 32'd0);
        check("hi_err_set",  32'(err_hi), 32'd1);

        // Sync resumes: err sticks, FSM restarts from SEARCH
        frame(mk(1023, H_SW, V_TOT, V_SW, 0, 1), H_TOT);
        frame(mk(H_TOT, H_SW, V_TOT, V_SW, 0, 1), H_TOT);
        sb_q.push_back(mk(H_TOT, H_SW, V_TOT, V_SW, 0, 1));
        lines(0, 4, H_TOT);

        // One-clock reset mid-frame
        @(posedge m_clock); #1;
        p_reset = 1'b0;
        @(posedge m_clock); #1;
        check_zero("midframe_reset");
        p_reset = 1'b1;
        lines(5, V_TOT - 1, H_TOT);
        frame(mk(H_TOT, H_SW, V_TOT - 4, 0, 0, 0), H_TOT);
        frame(mk(H_TOT, H_SW, V_TOT, V_SW, 0, 0), H_TOT);
        frame(mk(H_TOT, H_SW, V_TOT, V_SW, 0, 0), H_TOT);
        frame(mk(H_TOT, H_SW, V_TOT, V_SW, 1, 0), H_TOT);
        check("err_after_reset", 32'(err), 32'd0);

        repeat (10) @(posedge m_clock);
        check("frames_pending", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
